// File: rtl/s_chunk_feeder_if.sv
// Host/top-level facing signals of the S chunk feeder.
// Build option: ASCII_IN_EN widens i_sym to 8-bit ASCII characters.
interface s_chunk_feeder_if #(
  parameter int unsigned PE_SIZE     = 64,
  parameter int unsigned PE_SIZE_LOG = 6
);
`ifdef ASCII_IN_EN
  localparam int unsigned SYM_W = 8;
`else
  localparam int unsigned SYM_W = 2;
`endif

  logic                   i_start;
  logic [SYM_W-1:0]       i_sym;
  logic                   i_sym_valid;
  logic                   i_sym_last;
  logic                   o_sym_ready;
  logic                   i_request_s;
  logic [PE_SIZE*2-1:0]   o_s;
  logic [PE_SIZE_LOG:0]   o_s_valid;
  logic                   o_done;
  logic                   o_err;

  // Feeder side
  modport slave (
    input  i_start, i_sym, i_sym_valid, i_sym_last, i_request_s,
    output o_sym_ready, o_s, o_s_valid, o_done, o_err
  );

  // Host / top-level side
  modport master (
    output i_start, i_sym, i_sym_valid, i_sym_last, i_request_s,
    input  o_sym_ready, o_s, o_s_valid, o_done, o_err
  );
endinterface

// File: rtl/s_chunk_feeder.sv
// S (query) side feeder: packs 2-bit symbols into PE_SIZE-wide chunks, buffers them
// in a small FIFO and answers the top level's one-cycle chunk requests.
// Build option: ASCII_IN_EN accepts ASCII nucleotides and flags illegal characters on o_err.
module s_chunk_feeder #(
  parameter int unsigned PE_SIZE     = 64,
  parameter int unsigned PE_SIZE_LOG = 6,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned FIFO_LOG    = 2
) (
  input logic            clk,
  input logic            rst_n,
  s_chunk_feeder_if.slave bus
);

  localparam int unsigned DW = PE_SIZE * 2;
  localparam int unsigned CW = PE_SIZE_LOG + 1;
  localparam int unsigned PW = FIFO_LOG + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(PE_SIZE);

  typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_e;

  state_e              state_q;
  logic [DW-1:0]       asm_q;
  logic [CW-1:0]       sym_cnt_q;
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic                req_pending_q;
  logic [DW-1:0]       s_q;
  logic [CW-1:0]       s_valid_q;
  logic                done_q;

  logic [DW-1:0]       mem_data [FIFO_DEPTH];
  logic [CW-1:0]       mem_cnt  [FIFO_DEPTH];

  logic                fifo_empty, fifo_full;
  logic                sym_ready, accept, push, serve, req_take, active;
  logic                sym_legal;
  logic [1:0]          sym_code;
  logic [DW-1:0]       asm_next;
  logic [CW-1:0]       cnt_next;
  logic [FIFO_LOG-1:0] wr_idx, rd_idx;

  assign wr_idx     = wr_ptr_q[FIFO_LOG-1:0];
  assign rd_idx     = rd_ptr_q[FIFO_LOG-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_LOG] != rd_ptr_q[FIFO_LOG]) && (wr_idx == rd_idx);

  // Symbol decode: map the incoming symbol to a 2-bit code and flag whether it is usable
  always_comb begin
    sym_code  = 2'd0;
    sym_legal = 1'b0;
`ifdef ASCII_IN_EN
    case (bus.i_sym)
      8'h41, 8'h61: begin sym_code = 2'd0; sym_legal = 1'b1; end
      8'h43, 8'h63: begin sym_code = 2'd1; sym_legal = 1'b1; end
      8'h47, 8'h67: begin sym_code = 2'd2; sym_legal = 1'b1; end
      8'h54, 8'h74: begin sym_code = 2'd3; sym_legal = 1'b1; end
      default:      ;
    endcase
`else
    sym_code  = bus.i_sym;
    sym_legal = 1'b1;
`endif
  end

  // Handshake, chunk assembly and FIFO control decisions for this cycle
  always_comb begin
    active    = (state_q == StFill) || (state_q == StDrain);
    // Symbols presented alongside i_start are never taken
    sym_ready = (state_q == StFill) && !fifo_full && !bus.i_start;
    accept    = bus.i_sym_valid && sym_ready;

    asm_next = asm_q;
    for (int unsigned k = 0; k < PE_SIZE; k++) begin
      if (sym_legal && (sym_cnt_q == CW'(k))) asm_next[2*k +: 2] = sym_code;
    end
    cnt_next = sym_cnt_q + CW'(sym_legal);

    // Close a chunk when full, or on the last symbol if it holds anything
    push = accept && ((sym_legal && (cnt_next == FULL_CNT)) ||
                      (bus.i_sym_last && (cnt_next != '0)));

    // A new request is ignored while one is pending or its chunk is on the bus
    req_take = active && bus.i_request_s && !req_pending_q && (s_valid_q == '0) &&
               !bus.i_start;
    serve    = active && (req_take || req_pending_q) && !fifo_empty && !bus.i_start;
  end

  // Chunk storage; read only when non-empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_idx] <= asm_next;
      mem_cnt[wr_idx]  <= cnt_next;
    end
  end

  // Control FSM, FIFO pointers, request tracking and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      asm_q         <= '0;
      sym_cnt_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      req_pending_q <= 1'b0;
      s_q           <= '0;
      s_valid_q     <= '0;
      done_q        <= 1'b0;
    end else if (bus.i_start) begin
      state_q       <= StFill;
      asm_q         <= '0;
      sym_cnt_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      req_pending_q <= 1'b0;
      s_q           <= '0;
      s_valid_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      s_q       <= '0;
      s_valid_q <= '0;
      unique case (state_q)
        StIdle: ;
        StFill: begin
          if (accept) begin
            if (push) begin
              wr_ptr_q  <= wr_ptr_q + PW'(1);
              asm_q     <= '0;
              sym_cnt_q <= '0;
            end else begin
              asm_q     <= asm_next;
              sym_cnt_q <= cnt_next;
            end
            if (bus.i_sym_last) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (fifo_empty && !req_pending_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: ;
        default: state_q <= StIdle;
      endcase

      if (serve) begin
        s_q           <= mem_data[rd_idx];
        s_valid_q     <= mem_cnt[rd_idx];
        rd_ptr_q      <= rd_ptr_q + PW'(1);
        req_pending_q <= 1'b0;
      end else if (req_take) begin
        req_pending_q <= 1'b1;
      end
    end
  end

`ifdef ASCII_IN_EN
  logic err_q;

  // Sticky illegal-character flag, cleared only by a new sequence or reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    err_q <= 1'b0;
    else if (bus.i_start)          err_q <= 1'b0;
    else if (accept && !sym_legal) err_q <= 1'b1;
  end

  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif

  assign bus.o_sym_ready = sym_ready;
  assign bus.o_s         = s_q;
  assign bus.o_s_valid   = s_valid_q;
  assign bus.o_done      = done_q;

endmodule

// File: tb/tb_s_chunk_feeder.sv
// Self-checking bench for s_chunk_feeder with PE_SIZE=4, FIFO_DEPTH=2.
// Expected chunks are queued as symbols are accepted and compared when the DUT emits them.
module tb_s_chunk_feeder;

`ifdef ASCII_IN_EN
  localparam int unsigned SYM_W = 8;
`else
  localparam int unsigned SYM_W = 2;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] cnt;
  } chunk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  s_chunk_feeder_if #(.PE_SIZE(4), .PE_SIZE_LOG(2)) bus ();

  s_chunk_feeder #(
    .PE_SIZE     (4),
    .PE_SIZE_LOG (2),
    .FIFO_DEPTH  (2),
    .FIFO_LOG    (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  chunk_t exp_q[$];
  chunk_t mon_c;
  logic [7:0] acc_data = '0;
  int     acc_cnt = 0;
  int     accepted = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode of a host symbol; -1 means not a nucleotide
  function automatic int sym_val(input logic [SYM_W-1:0] s);
`ifdef ASCII_IN_EN
    case (s)
      8'h41, 8'h61: return 0;
      8'h43, 8'h63: return 1;
      8'h47, 8'h67: return 2;
      8'h54, 8'h74: return 3;
      default:      return -1;
    endcase
`else
    return int'(s);
`endif
  endfunction

  function automatic logic [SYM_W-1:0] enc(input int v);
`ifdef ASCII_IN_EN
    case (v)
      0:       return 8'h41;
      1:       return 8'h43;
      2:       return 8'h47;
      default: return 8'h54;
    endcase
`else
    return SYM_W'(v);
`endif
  endfunction

  task automatic model_accept(input logic [SYM_W-1:0] s, input logic last);
    int v;
    chunk_t c;
    v = sym_val(s);
    accepted++;
    if (v >= 0) begin
      acc_data[2*acc_cnt +: 2] = v[1:0];
      acc_cnt++;
    end
    if ((v >= 0 && acc_cnt == 4) || (last && acc_cnt != 0)) begin
      c.data = acc_data;
      c.cnt  = 3'(acc_cnt);
      exp_q.push_back(c);
      acc_data = '0;
      acc_cnt  = 0;
    end
  endtask

  // Present one symbol and hold it until accepted (bounded)
  task automatic send_sym(input logic [SYM_W-1:0] s, input logic last);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    bus.i_sym       = s;
    bus.i_sym_valid = 1'b1;
    bus.i_sym_last  = last;
    while (!got && n < 200) begin
      @(negedge clk);
      if (bus.o_sym_ready) begin
        @(posedge clk);
        model_accept(s, last);
        got = 1'b1;
      end else begin
        @(posedge clk);
        n++;
      end
    end
    #1;
    bus.i_sym_valid = 1'b0;
    bus.i_sym_last  = 1'b0;
    if (!got) check_eq("sym_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_seq();
    @(posedge clk);
    #1 bus.i_start = 1'b1;
    @(posedge clk);
    exp_q.delete();
    acc_data = '0;
    acc_cnt  = 0;
    accepted = 0;
    #1 bus.i_start = 1'b0;
  endtask

  task automatic request();
    @(posedge clk);
    #1 bus.i_request_s = 1'b1;
    @(posedge clk);
    #1 bus.i_request_s = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!bus.o_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(bus.o_done), 32'd1);
  endtask

  // Scoreboard: every emitted chunk must match the oldest expected one
  always @(negedge clk) begin
    if (rst_n && bus.o_s_valid != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_chunk", 32'(bus.o_s_valid), 32'd0);
      end else begin
        mon_c = exp_q.pop_front();
        check_eq("chunk_data", 32'(bus.o_s), 32'(mon_c.data));
        check_eq("chunk_cnt", 32'(bus.o_s_valid), 32'(mon_c.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.i_start     = 1'b0;
    bus.i_sym       = '0;
    bus.i_sym_valid = 1'b0;
    bus.i_sym_last  = 1'b0;
    bus.i_request_s = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(bus.o_sym_ready), 32'd0);
    check_eq("rst_s", 32'(bus.o_s), 32'd0);
    check_eq("rst_s_valid", 32'(bus.o_s_valid), 32'd0);
    check_eq("rst_done", 32'(bus.o_done), 32'd0);
    check_eq("rst_err", 32'(bus.o_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", 32'(bus.o_sym_ready), 32'd0);

    // Single full chunk, one-cycle request latency
    start_seq();
    for (int i = 0; i < 4; i++) send_sym(enc(i), i == 3);
    repeat (2) @(posedge clk);
    #1;
    request();
    @(negedge clk);
    check_eq("single_latency", 32'(bus.o_s_valid), 32'd4);
    check_eq("single_data", 32'(bus.o_s), 32'hE4);
    wait_done("single_done");

    // Partial tail chunk, then a request in DONE must be ignored
    start_seq();
    for (int i = 0; i < 6; i++) send_sym(enc(2), i == 5);
    request();
    repeat (3) @(posedge clk);
    request();
    wait_done("tail_done");
    request();
    repeat (4) @(posedge clk);
    check_eq("tail_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure: FIFO fills after 8 symbols, then drains by request
    start_seq();
    fork
      begin
        for (int i = 0; i < 12; i++) send_sym(enc(int'($urandom_range(0, 3))), i == 11);
      end
      begin
        repeat (30) @(posedge clk);
        @(negedge clk);
        check_eq("bp_accepted", 32'(accepted), 32'd8);
        check_eq("bp_ready_low", 32'(bus.o_sym_ready), 32'd0);
        for (int r = 0; r < 3; r++) begin
          request();
          repeat (4) @(posedge clk);
        end
      end
    join
    wait_done("bp_done");
    check_eq("bp_total", 32'(accepted), 32'd12);
    check_eq("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Pending request served one cycle after the FIFO becomes non-empty
    start_seq();
    request();
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_sym(enc(3 - i), i == 3);
    @(negedge clk);
    check_eq("pend_early", 32'(bus.o_s_valid), 32'd0);
    @(negedge clk);
    check_eq("pend_serve", 32'(bus.o_s_valid), 32'd4);
    check_eq("pend_data", 32'(bus.o_s), 32'h1B);
    @(negedge clk);
    check_eq("pend_once", 32'(bus.o_s_valid), 32'd0);
    wait_done("pend_done");

    // Restart mid-FILL with one chunk buffered: old data must vanish
    start_seq();
    for (int i = 0; i < 4; i++) send_sym(enc(1), 1'b0);
    for (int i = 0; i < 2; i++) send_sym(enc(2), 1'b0);
    repeat (2) @(posedge clk);
    start_seq();
    @(negedge clk);
    check_eq("restart_done_low", 32'(bus.o_done), 32'd0);
    check_eq("restart_ready", 32'(bus.o_sym_ready), 32'd1);
    request();
    repeat (6) @(posedge clk);
    #1;
    send_sym(enc(3), 1'b0);
    send_sym(enc(0), 1'b0);
    send_sym(enc(3), 1'b1);
    wait_done("restart_done");
    check_eq("restart_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef ASCII_IN_EN
    // Mixed-case ASCII with one illegal character
    start_seq();
    send_sym(8'h41, 1'b0);
    send_sym(8'h63, 1'b0);
    send_sym(8'h58, 1'b0);
    send_sym(8'h47, 1'b0);
    send_sym(8'h74, 1'b1);
    request();
    @(negedge clk);
    check_eq("ascii_data", 32'(bus.o_s), 32'hE4);
    check_eq("ascii_cnt", 32'(bus.o_s_valid), 32'd4);
    wait_done("ascii_done");
    check_eq("ascii_err", 32'(bus.o_err), 32'd1);
    start_seq();
    @(negedge clk);
    check_eq("ascii_err_clear", 32'(bus.o_err), 32'd0);
`else
    check_eq("err_tied_low", 32'(bus.o_err), 32'd0);
`endif

    repeat (3) @(posedge clk);
    check_eq("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/s_chunk_feeder.md
Name: s_chunk_feeder

Overview:
- Upstream feeder for the S (query) side of the Smith-Waterman array top level.
- Accepts a stream of 2-bit nucleotide symbols from the host and packs them into PE-array-wide chunks.
- Buffers the chunks in a small FIFO and answers the top level's S request handshake with one chunk plus its valid-symbol count.
- Replaces direct host driving of the S-chunk and S-valid inputs.

Parameters:
- PE_SIZE, 64, symbols per chunk (equals PE array size).
- PE_SIZE_LOG, 6, log2(PE_SIZE).
- FIFO_DEPTH, 4, chunk FIFO entries (power of 2, >=2).
- FIFO_LOG, 2, log2(FIFO_DEPTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  pulse: flush and begin accepting a new S sequence.
- i_sym  in  2 (8 with ASCII_IN_EN)  input symbol, A=0 C=1 G=2 T=3.
- i_sym_valid  in  1  symbol valid.
- i_sym_last  in  1  qualifies final symbol of the sequence.
- o_sym_ready  out  1  symbol accepted when valid&ready.
- i_request_s  in  1  one-cycle chunk request from the top level.
- o_s  out  PE_SIZE*2  chunk data; symbol k at bits [2k+1:2k], first symbol at k=0.
- o_s_valid  out  PE_SIZE_LOG+1  number of valid symbols in o_s; 0 = no chunk this cycle.
- o_done  out  1  level: whole sequence delivered.
- o_err  out  1  sticky illegal-character flag (ASCII_IN_EN only; tied 0 otherwise).

Behaviour:
- Reset values: o_sym_ready=0, o_s=0, o_s_valid=0, o_done=0, o_err=0, state IDLE, FIFO empty, pending request cleared.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE: o_sym_ready=0; i_start -> FILL.
- FILL: o_sym_ready = ~fifo_full.
  - Each accepted symbol is written into the assembly register at index sym_cnt; sym_cnt increments.
  - The chunk is pushed to the FIFO with count when sym_cnt reaches PE_SIZE, or on the accepted i_sym_last symbol.
  - After a push, the assembly register is zeroed and sym_cnt is set to 0.
  - Accepted last symbol -> DRAIN.
- DRAIN: o_sym_ready=0; FIFO empty and no pending request -> DONE.
- DONE: o_done=1; requests produce no response; i_start -> FILL.
- i_start in any state (restart mid-operation):
  - Next cycle: FIFO, assembly register, sym_cnt, pending request and o_done are cleared; state = FILL.
  - Any symbol presented in the i_start cycle is not accepted; o_sym_ready=0 that cycle.
- Request handshake:
  - i_request_s sampled in cycle N with FIFO non-empty: in cycle N+1 o_s/o_s_valid show the head entry for exactly one cycle, and the entry is popped.
  - FIFO empty in FILL/DRAIN: the request becomes pending and is served in the first cycle the FIFO is non-empty, with 1-cycle latency from that point.
  - Push and pop in the same cycle are both performed. A push into an empty FIFO is not bypassed: it is visible the following cycle.
  - A second request while one is pending or being served is ignored.
  - When no chunk is presented: o_s=0 and o_s_valid=0.
- Sequence length:
  - Length L>=1.
  - Chunks = ceil(L/PE_SIZE); all full except possibly the last, which carries L mod PE_SIZE symbols.
  - If L is a multiple of PE_SIZE, the last chunk has count PE_SIZE and no zero-count chunk is ever emitted.
- i_sym_last with i_sym_valid=0 has no effect.
- Full FIFO: input stalls via o_sym_ready=0; no symbol is lost or duplicated.
- Widths: sym_cnt is PE_SIZE_LOG+1 bits. FIFO pointers are FIFO_LOG+1 bits with wrap bit; full = pointers equal except MSB.

Optional Feature:
- Macro ASCII_IN_EN.
- Defined:
  - i_sym is 8-bit ASCII; A/a->0, C/c->1, G/g->2, T/t->3.
  - Any other accepted character is dropped: not counted, not packed, and sets o_err sticky until i_start or reset.
  - An illegal character carrying i_sym_last still ends the sequence, closing any partial chunk.
  - A sequence consisting only of illegal characters emits no chunk and goes straight to DONE after DRAIN.
- Undefined: i_sym is 2 bits used directly; o_err constant 0.

Test Plan (PE_SIZE=4, PE_SIZE_LOG=2, FIFO_DEPTH=2, FIFO_LOG=1):
- Single chunk: start, symbols 0,1,2,3 (last on 3), request -> next cycle o_s=8'b11100100, o_s_valid=4, then o_done=1.
- Partial tail: 6 symbols all =2, two requests -> o_s=8'hAA/valid=4, then o_s=8'h0A/valid=2; no third chunk, o_done=1.
- Backpressure: stream 12 symbols with no requests -> o_sym_ready drops after 8 accepted. Then 3 requests -> counts 4,4,4, all 12 symbols in order, no loss or duplication.
- Pending request: request right after start, with first symbol 5 cycles later -> chunk appears 1 cycle after the FIFO becomes non-empty, exactly once.
- Restart: i_start mid-FILL with 1 chunk buffered -> FIFO empty; next request gets only new-sequence data; o_done=0.
- ASCII_IN_EN: "AcXGt" with last on 't' -> o_s=8'b11100100, valid=4, o_err=1; a following i_start clears o_err.
